load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Initiator/master for the byte-addressed data RAM port (write_EN/read_EN/data_type/address/write_data/read_data).
- Accepts one load/store per transaction from the core's memory stage over a valid/ready handshake.
- Encodes RV32I funct3 into the RAM access size, drives the RAM control for exactly one cycle, and captures the registered read data.
- Returns sign- or zero-extended load data, or an error response for misaligned or illegal requests.

Parameters:
- MEM_LATENCY, 1: cycles from the edge that samples read_EN to valid read_data; legal range 1..4.
- CHECK_ALIGN, 1: 1 = halfword/word accesses must be naturally aligned; 0 = pass any address through.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  LSU can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low-aligned
- resp_valid  out  1  response available
- resp_ready  in  1  core accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_misaligned  out  1  alignment fault; no memory access performed
- resp_illegal  out  1  unsupported funct3; no memory access performed
- mem_write_EN  out  1  RAM write enable
- mem_read_EN  out  1  RAM read enable
- mem_data_type  out  2  00 word, 01 halfword, 10 byte
- mem_address  out  32  RAM byte address
- mem_write_data  out  32  RAM write data
- mem_read_data  in  32  RAM registered read data, zero-extended by size

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; req_ready = 1.
  - resp_valid, resp_misaligned, resp_illegal, mem_write_EN, mem_read_EN = 0.
  - resp_rdata, mem_address, mem_write_data = 0; mem_data_type = 00.
  - Reset mid-transaction aborts it immediately; enables drop asynchronously, and no response is produced after reset.
- All mem_* and resp_* outputs are registered. req_ready = (state == IDLE).
- Acceptance: req_valid && req_ready at a rising edge. Capture write, funct3, addr and wdata.
- Decode at acceptance:
  - Illegal: loads with funct3 011/110/111; stores with funct3 > 010.
  - Misaligned (only when CHECK_ALIGN = 1): halfword with addr[0] = 1, or word with addr[1:0] != 0.
  - Illegal takes priority over misaligned.
- States:
  - IDLE:
    - Accepted and faulted -> RESP with the fault flag set and rdata = 0.
    - Accepted and legal -> ISSUE.
  - ISSUE (1 cycle): drive mem_address, mem_data_type and mem_write_data; exactly one of mem_write_EN/mem_read_EN = 1.
    - Store -> RESP.
    - Load -> WAIT.
    - Both enables return to 0 on leaving ISSUE, so there is one RAM access per request.
  - WAIT (MEM_LATENCY cycles, counter): at the edge ending the last WAIT cycle, sample mem_read_data, extend it, and load resp_rdata.
    - The sample must happen in the first cycle in which data is valid. The RAM clears read_data once read_EN deasserts, so late sampling reads 0.
    - Then -> RESP.
  - RESP: resp_valid = 1; hold resp_* stable until resp_valid && resp_ready, then -> IDLE.
    - resp_ready asserted on the first RESP cycle gives a single-cycle response.
- Latency from acceptance edge to first resp_valid cycle:
  - Load: 2 + MEM_LATENCY cycles (3 by default).
  - Store: 2 cycles.
  - Fault: 1 cycle.
  - A request can be accepted no earlier than the cycle after the response handshake; there is no back-to-back overlap.
- Extension:
  - LB sign-extends bit 7; LH sign-extends bit 15.
  - LBU and LHU zero-extend.
  - LW passes all 32 bits.
- mem_write_data = req_wdata unmodified; the RAM consumes the low byte or halfword.
- mem_address is not truncated here; the RAM wraps it to its size.
- req_valid while busy is ignored; the request must be held by the core.

Decomposition:
- Shared package/include lsu_defs:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - Data-type encodings (DT_WORD = 00, DT_HALF = 01, DT_BYTE = 10).
  - State encodings (IDLE, ISSUE, WAIT, RESP).
- One natural sub-module: load_extend, combinational (funct3, raw 32-bit data) -> extended 32-bit data. It is reused by writeback-path checks.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, then LW 0x100 -> ISSUE shows mem_write_EN = 1, data_type = 00 for one cycle. Load resp_valid 3 cycles after acceptance with rdata 0xDEADBEEF.
- SB 0x80 wdata 0x000000F0, then LB 0x80 -> rdata 0xFFFFFFF0; LBU 0x80 -> 0x000000F0; SH 0x84 0x8001 then LH -> 0xFFFF8001, LHU -> 0x00008001.
- LW 0x102 with CHECK_ALIGN = 1 -> resp_misaligned = 1 one cycle after acceptance, rdata = 0, neither mem enable ever asserts. Same with CHECK_ALIGN = 0 -> normal access at 0x102.
- Load funct3 = 011 and store funct3 = 100 -> resp_illegal = 1, no mem enable. Misaligned + illegal -> only resp_illegal.
- Hold resp_ready = 0 for 5 cycles on LW -> resp_valid and rdata stable throughout; req_ready stays 0; a req_valid pulse during that window is not accepted.
- Pull rst_n low during WAIT -> all outputs 0 immediately, req_ready = 1 after release, no stale resp_valid. MEM_LATENCY = 3 variant -> load resp 5 cycles after acceptance with correct data.

Source files
------------

// File: rtl/lsu_defs_pkg.sv
// Shared encodings for the load/store unit: RV32I funct3 values, RAM access sizes,
// controller states and small decode helpers.
package lsu_defs;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] DT_WORD = 2'b00;
    localparam logic [1:0] DT_HALF = 2'b01;
    localparam logic [1:0] DT_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } lsu_state_t;

    // Loads accept B/H/W/BU/HU; stores only B/H/W.
    function automatic logic f3_illegal(input logic write, input logic [2:0] f3);
        if (write)
            f3_illegal = (f3 > F3_W);
        else
            f3_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // Size comes from funct3[1:0]; the unsigned variants share the signed sizes.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lsb);
        case (f3[1:0])
            2'b01:   f3_misaligned = lsb[0];
            2'b10:   f3_misaligned = (lsb != 2'b00);
            default: f3_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] f3_to_dt(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   f3_to_dt = DT_BYTE;
            2'b01:   f3_to_dt = DT_HALF;
            default: f3_to_dt = DT_WORD;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data extension: sign- or zero-extends the raw RAM word
// according to the RV32I load funct3.
module load_extend
    import lsu_defs::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw_data,
    output logic [31:0] ext_data
);

    always_comb begin
        ext_data = raw_data;
        case (funct3)
            F3_B:    ext_data = {{24{raw_data[7]}}, raw_data[7:0]};
            F3_H:    ext_data = {{16{raw_data[15]}}, raw_data[15:0]};
            F3_BU:   ext_data = {24'h000000, raw_data[7:0]};
            F3_HU:   ext_data = {16'h0000, raw_data[15:0]};
            default: ext_data = raw_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: takes one request at a time from the memory stage, performs a single
// RAM access and returns extended load data or a fault response.
module load_store_unit
    import lsu_defs::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter bit CHECK_ALIGN = 1'b1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_illegal,
    output logic        mem_write_EN,
    output logic        mem_read_EN,
    output logic [1:0]  mem_data_type,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam int CNT_W = 3;

    lsu_state_t state_reg, state_next;

    logic             is_write_reg;
    logic [2:0]       funct3_reg;
    logic [CNT_W-1:0] wait_cnt_reg;

    logic        accept;
    logic        req_illegal;
    logic        req_misaligned;
    logic        req_fault;
    logic [31:0] ext_data;

    assign req_ready      = (state_reg == IDLE);
    assign accept         = req_valid && req_ready;
    assign req_illegal    = f3_illegal(req_write, req_funct3);
    assign req_misaligned = CHECK_ALIGN && f3_misaligned(req_funct3, req_addr[1:0]);
    assign req_fault      = req_illegal || req_misaligned;

    load_extend u_load_extend (
        .funct3   (funct3_reg),
        .raw_data (mem_read_data),
        .ext_data (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = req_fault ? RESP : ISSUE;
            ISSUE:   state_next = is_write_reg ? RESP : WAIT;
            WAIT:    if (wait_cnt_reg == '0) state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs; enables are only ever high for the ISSUE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_write_reg    <= 1'b0;
            funct3_reg      <= 3'b000;
            wait_cnt_reg    <= '0;
            resp_valid      <= 1'b0;
            resp_rdata      <= 32'h0;
            resp_misaligned <= 1'b0;
            resp_illegal    <= 1'b0;
            mem_write_EN    <= 1'b0;
            mem_read_EN     <= 1'b0;
            mem_data_type   <= DT_WORD;
            mem_address     <= 32'h0;
            mem_write_data  <= 32'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        is_write_reg    <= req_write;
                        funct3_reg      <= req_funct3;
                        resp_rdata      <= 32'h0;
                        resp_illegal    <= req_illegal;
                        resp_misaligned <= req_misaligned && !req_illegal;
                        if (req_fault) begin
                            resp_valid <= 1'b1;
                        end else begin
                            mem_address    <= req_addr;
                            mem_data_type  <= f3_to_dt(req_funct3);
                            mem_write_data <= req_wdata;
                            mem_write_EN   <= req_write;
                            mem_read_EN    <= !req_write;
                        end
                    end
                end
                ISSUE: begin
                    mem_write_EN <= 1'b0;
                    mem_read_EN  <= 1'b0;
                    wait_cnt_reg <= CNT_W'(MEM_LATENCY - 1);
                    if (is_write_reg)
                        resp_valid <= 1'b1;
                end
                WAIT: begin
                    // The RAM zeroes read_data right after the valid cycle, so sample exactly here.
                    if (wait_cnt_reg == '0) begin
                        resp_rdata <= ext_data;
                        resp_valid <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready)
                        resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
